// File: rtl/pong_ball_if.sv
// pong_ball_if -- signal bundle between the paddle/frame logic and the
// ball engine.
//
//   refresh_tick  one-clk pulse per frame (motion happens only on it)
//   serve         level; launches the ball / restarts after game over
//   paddle_l_y    left paddle top y
//   paddle_r_y    right paddle top y
//   ball_x/ball_y ball top-left corner
//   score_l/_r    player scores
//   hit           one-clk pulse on a paddle bounce
//   point_l/_r    one-clk pulse when that player scores
//   game_over     high while the game is over
//
// master: the environment driving frame/paddle/serve inputs.
// slave : the ball engine.
interface pong_ball_if;
  logic       refresh_tick;
  logic       serve;
  logic [9:0] paddle_l_y;
  logic [9:0] paddle_r_y;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score_l;
  logic [3:0] score_r;
  logic       hit;
  logic       point_l;
  logic       point_r;
  logic       game_over;

  modport master (
    output refresh_tick, serve, paddle_l_y, paddle_r_y,
    input  ball_x, ball_y, score_l, score_r, hit, point_l, point_r, game_over
  );

  modport slave (
    input  refresh_tick, serve, paddle_l_y, paddle_r_y,
    output ball_x, ball_y, score_l, score_r, hit, point_l, point_r, game_over
  );
endinterface

// File: rtl/pong_ball.sv
// pong_ball -- ball motion and scoring engine.
//
// Moves the ball once per refresh_tick while in play, resolves wall and
// paddle collisions, keeps both scores and sequences
// SERVE -> PLAY -> POINT -> (SERVE | GAME_OVER).
//
// Ports:
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      pong_ball_if.slave: refresh_tick, serve, paddle_l_y,
//            paddle_r_y in; ball_x, ball_y, score_l, score_r, hit,
//            point_l, point_r, game_over out
module pong_ball #(
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int BALL_SIZE     = 8,
  parameter int BALL_SPEED    = 2,
  parameter int PADDLE_HEIGHT = 72,
  parameter int L_PADDLE_FACE = 40,
  parameter int R_PADDLE_FACE = 600,
  parameter int POINT_FRAMES  = 60,
  parameter int WIN_SCORE     = 7
) (
  input  logic        clk,
  input  logic        reset_n,
  pong_ball_if.slave  bus
);

  // All geometry is compared in 11 bits so paddle_y + PADDLE_HEIGHT cannot
  // wrap even for a paddle parked off-screen near 1023.
  localparam logic [10:0] W11 = 11'(SCREEN_W);
  localparam logic [10:0] H11 = 11'(SCREEN_H);
  localparam logic [10:0] SZ  = 11'(BALL_SIZE);
  localparam logic [10:0] SPD = 11'(BALL_SPEED);
  localparam logic [10:0] PH  = 11'(PADDLE_HEIGHT);
  localparam logic [10:0] LF  = 11'(L_PADDLE_FACE);
  localparam logic [10:0] RF  = 11'(R_PADDLE_FACE);
  localparam logic [9:0]  CX  = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0]  CY  = 10'((SCREEN_H - BALL_SIZE) / 2);
  localparam logic [3:0]  WIN = 4'(WIN_SCORE);
  localparam int          FW  = $clog2(POINT_FRAMES + 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(POINT_FRAMES - 1);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_POINT, S_OVER} state_t;

  state_t        state, state_nx;
  logic [9:0]    ball_x, ball_y;
  logic          dir_x;      // 1 = moving right
  logic          dir_y;      // 1 = moving down
  logic          serve_dy;   // vertical direction the next serve uses
  logic          armed;      // serve has been seen low since last consumed
  logic [3:0]    score_l, score_r;
  logic          hit, point_l, point_r;
  logic [FW-1:0] frame_cnt;
  logic          game_over;

  logic          launch, frame_done, win_reached, arm_clr;
  logic [10:0]   x11, y11, pl11, pr11;
  logic [9:0]    y_nx;
  logic          dy_nx;
  logic          ovl_l, ovl_r, bounce_l, bounce_r, miss_l, miss_r;

  assign x11  = {1'b0, ball_x};
  assign y11  = {1'b0, ball_y};
  assign pl11 = {1'b0, bus.paddle_l_y};
  assign pr11 = {1'b0, bus.paddle_r_y};

  assign launch      = bus.serve && armed;
  assign frame_done  = (frame_cnt == FRAME_LAST);
  assign win_reached = (score_l == WIN) || (score_r == WIN);

  // Vertical step: clamp to the wall and reverse when the next step would
  // touch or cross it.
  always_comb begin
    y_nx  = ball_y;
    dy_nx = dir_y;
    if (!dir_y) begin
      if (y11 <= SPD) begin
        y_nx  = '0;
        dy_nx = 1'b1;
      end else begin
        y_nx = 10'(y11 - SPD);
      end
    end else begin
      if (y11 + SZ + SPD >= H11) begin
        y_nx  = 10'(H11 - SZ);
        dy_nx = 1'b0;
      end else begin
        y_nx = 10'(y11 + SPD);
      end
    end
  end

  assign ovl_l = (y11 + SZ > pl11) && (y11 < pl11 + PH);
  assign ovl_r = (y11 + SZ > pr11) && (y11 < pr11 + PH);

  // The "not yet past the face" term makes a ball that slipped by a paddle
  // unable to bounce back off its rear.
  assign bounce_r = dir_x && (x11 + SZ + SPD >= RF) && (x11 + SZ <= RF) && ovl_r;
  assign miss_r   = dir_x && !bounce_r && (x11 + SZ + SPD >= W11);
  assign bounce_l = !dir_x && (x11 <= LF + SPD) && (x11 >= LF) && ovl_l;
  assign miss_l   = !dir_x && !bounce_l && (x11 <= SPD);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_SERVE;
    else          state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_SERVE: if (launch) state_nx = S_PLAY;
      S_PLAY:  if (bus.refresh_tick && (miss_l || miss_r)) state_nx = S_POINT;
      S_POINT: if (bus.refresh_tick && frame_done)
                 state_nx = win_reached ? S_OVER : S_SERVE;
      S_OVER:  if (launch) state_nx = S_SERVE;
      default: state_nx = S_SERVE;
    endcase
  end

  // Output logic
  always_comb begin
    game_over = 1'b0;
    if (state == S_OVER) game_over = 1'b1;
  end

  // Serve must be seen low again after game over is entered and after the
  // restart press, so a held button cannot skip straight through.
  assign arm_clr = ((state_nx == S_OVER) && (state != S_OVER)) ||
                   ((state == S_OVER) && launch);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) armed <= 1'b1;
    else          armed <= !bus.serve || (armed && !arm_clr);
  end

  // Ball, direction, score and pulse datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ball_x    <= CX;
      ball_y    <= CY;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      serve_dy  <= 1'b1;
      score_l   <= '0;
      score_r   <= '0;
      hit       <= 1'b0;
      point_l   <= 1'b0;
      point_r   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      hit     <= 1'b0;
      point_l <= 1'b0;
      point_r <= 1'b0;
      case (state)
        S_SERVE: begin
          ball_x <= CX;
          ball_y <= CY;
          // The serve takes the stored direction and flips it for the next
          // one, so the very first serve after reset goes down.
          if (launch) begin
            dir_y    <= serve_dy;
            serve_dy <= !serve_dy;
          end
        end
        S_PLAY: begin
          if (bus.refresh_tick) begin
            ball_y <= y_nx;
            dir_y  <= dy_nx;
            if (bounce_r) begin
              ball_x <= 10'(RF - SZ);
              dir_x  <= 1'b0;
              hit    <= 1'b1;
            end else if (miss_r) begin
              // dir_x is left pointing at the losing side for the next serve
              if (score_l != WIN) score_l <= score_l + 4'd1;
              point_l   <= 1'b1;
              frame_cnt <= '0;
            end else if (bounce_l) begin
              ball_x <= 10'(LF);
              dir_x  <= 1'b1;
              hit    <= 1'b1;
            end else if (miss_l) begin
              if (score_r != WIN) score_r <= score_r + 4'd1;
              point_r   <= 1'b1;
              frame_cnt <= '0;
            end else if (dir_x) begin
              ball_x <= 10'(x11 + SPD);
            end else begin
              ball_x <= 10'(x11 - SPD);
            end
          end
        end
        S_POINT: begin
          if (bus.refresh_tick) begin
            if (frame_done) begin
              frame_cnt <= '0;
              ball_x    <= CX;
              ball_y    <= CY;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        S_OVER: begin
          ball_x <= CX;
          ball_y <= CY;
          if (launch) begin
            score_l <= '0;
            score_r <= '0;
            dir_x   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ball_x    = ball_x;
  assign bus.ball_y    = ball_y;
  assign bus.score_l   = score_l;
  assign bus.score_r   = score_r;
  assign bus.hit       = hit;
  assign bus.point_l   = point_l;
  assign bus.point_r   = point_r;
  assign bus.game_over = game_over;

endmodule

// File: tb/tb_pong_ball.sv
module tb_pong_ball;
  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  pong_ball_if bus ();
  pong_ball dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int total = 0;
  int bad   = 0;

  typedef struct {
    string      name;
    logic [9:0] pl;
    logic [9:0] pr;
    int         nt;   // ticks to apply; expectation checked after the last
    logic [9:0] ex;
    logic [9:0] ey;
    logic       eh;
  } vec_t;

  vec_t vt[11];
  vec_t sb[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic do_tick();
    @(negedge clk) bus.refresh_tick = 1'b1;
    @(negedge clk) bus.refresh_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) do_tick();
  endtask

  task automatic press_serve();
    @(negedge clk) bus.serve = 1'b1;
    @(negedge clk) bus.serve = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic chk_centre(input string nm);
    chk({nm, "_x"}, 32'(bus.ball_x), 32'd316);
    chk({nm, "_y"}, 32'(bus.ball_y), 32'd236);
  endtask

  initial begin
    vec_t e;
    bus.refresh_tick = 1'b0;
    bus.serve        = 1'b0;
    bus.paddle_l_y   = 10'd100;
    bus.paddle_r_y   = 10'd400;

    // name, pl, pr, ticks, x, y, hit
    vt[0]  = '{"run117",     10'd100, 10'd400, 117, 10'd550, 10'd470, 1'b0};
    vt[1]  = '{"bot_bounce", 10'd100, 10'd400, 1,   10'd552, 10'd472, 1'b0};
    vt[2]  = '{"pre_rhit",   10'd100, 10'd400, 19,  10'd590, 10'd434, 1'b0};
    vt[3]  = '{"r_hit",      10'd100, 10'd400, 1,   10'd592, 10'd432, 1'b1};
    vt[4]  = '{"after_rhit", 10'd100, 10'd400, 1,   10'd590, 10'd430, 1'b0};
    vt[5]  = '{"top_near",   10'd100, 10'd400, 214, 10'd162, 10'd2,   1'b0};
    vt[6]  = '{"top_bounce", 10'd100, 10'd400, 1,   10'd160, 10'd0,   1'b0};
    vt[7]  = '{"top_down",   10'd100, 10'd400, 1,   10'd158, 10'd2,   1'b0};
    vt[8]  = '{"pre_lhit",   10'd100, 10'd400, 58,  10'd42,  10'd118, 1'b0};
    vt[9]  = '{"l_hit",      10'd100, 10'd400, 1,   10'd40,  10'd120, 1'b1};
    vt[10] = '{"after_lhit", 10'd100, 10'd400, 1,   10'd42,  10'd122, 1'b0};

    // Reset state
    reset_n = 1'b0;
    #12;
    chk_centre("rst");
    chk("rst_sl",   32'(bus.score_l),   0);
    chk("rst_sr",   32'(bus.score_r),   0);
    chk("rst_hit",  32'(bus.hit),       0);
    chk("rst_pl",   32'(bus.point_l),   0);
    chk("rst_pr",   32'(bus.point_r),   0);
    chk("rst_go",   32'(bus.game_over), 0);
    @(negedge clk) reset_n = 1'b1;

    // Ticks in SERVE do nothing
    ticks(3);
    chk_centre("serve_idle");

    // Table: one continuous rally with bottom/top wall and both paddle bounces
    press_serve();
    foreach (vt[i]) begin
      bus.paddle_l_y = vt[i].pl;
      bus.paddle_r_y = vt[i].pr;
      if (vt[i].nt > 1) ticks(vt[i].nt - 1);
      sb.push_back(vt[i]);
      do_tick();
      e = sb.pop_front();
      chk({e.name, "_x"},   32'(bus.ball_x), 32'(e.ex));
      chk({e.name, "_y"},   32'(bus.ball_y), 32'(e.ey));
      chk({e.name, "_hit"}, 32'(bus.hit),    32'(e.eh));
      @(negedge clk);
      chk({e.name, "_hitlen"}, 32'(bus.hit), 0);
    end

    // Right paddle out of reach -> left scores, POINT hold, recentre
    do_reset();
    bus.paddle_l_y = 10'd100;
    bus.paddle_r_y = 10'd0;
    press_serve();
    ticks(157);
    chk("miss_pre_x", 32'(bus.ball_x), 630);
    do_tick();
    chk("miss_pl",  32'(bus.point_l), 1);
    chk("miss_sl",  32'(bus.score_l), 1);
    chk("miss_hit", 32'(bus.hit),     0);
    @(negedge clk);
    chk("miss_pl_len", 32'(bus.point_l), 0);
    ticks(59);
    chk("point_frozen_x", 32'(bus.ball_x), 630);
    do_tick();
    chk_centre("point_end");
    chk("point_end_go", 32'(bus.game_over), 0);

    // Second serve goes up: hits the top wall at tick 118
    bus.paddle_r_y = 10'd1000;
    press_serve();
    ticks(117);
    chk("up_pre_y", 32'(bus.ball_y), 2);
    do_tick();
    chk("up_top_y", 32'(bus.ball_y), 0);
    do_tick();
    chk("up_down_y", 32'(bus.ball_y), 2);
    ticks(38);
    do_tick();
    chk("s2_sl", 32'(bus.score_l), 2);
    ticks(60);

    // Remaining points up to WIN_SCORE, then game over with serve held
    for (int s = 3; s <= 7; s++) begin
      press_serve();
      ticks(157);
      do_tick();
      chk($sformatf("win_sl%0d", s), 32'(bus.score_l), 32'(s));
      chk($sformatf("win_pl%0d", s), 32'(bus.point_l), 1);
      if (s < 7) ticks(60);
    end
    bus.serve = 1'b1;
    ticks(59);
    chk("pre_go", 32'(bus.game_over), 0);
    do_tick();
    chk("go", 32'(bus.game_over), 1);
    chk_centre("go");
    repeat (5) @(negedge clk);
    chk("go_held",    32'(bus.game_over), 1);
    chk("go_held_sl", 32'(bus.score_l),   7);
    bus.serve = 1'b0;
    @(negedge clk);
    @(negedge clk) bus.serve = 1'b1;
    @(negedge clk);
    chk("restart_go", 32'(bus.game_over), 0);
    chk("restart_sl", 32'(bus.score_l),   0);
    chk("restart_sr", 32'(bus.score_r),   0);
    bus.serve = 1'b0;
    press_serve();
    do_tick();
    chk("restart_dir_x", 32'(bus.ball_x), 318);

    // Left paddle out of reach -> right scores; next serve heads left
    do_reset();
    bus.paddle_l_y = 10'd1000;
    bus.paddle_r_y = 10'd400;
    press_serve();
    ticks(138);
    chk("r2_hit_x", 32'(bus.ball_x), 592);
    ticks(295);
    chk("r2_pre_x", 32'(bus.ball_x), 2);
    do_tick();
    chk("r2_pr", 32'(bus.point_r), 1);
    chk("r2_sr", 32'(bus.score_r), 1);
    chk("r2_sl", 32'(bus.score_l), 0);
    ticks(60);
    chk_centre("r2_recentre");
    press_serve();
    do_tick();
    chk("r2_serve_left", 32'(bus.ball_x), 314);

    // Asynchronous reset between ticks in PLAY
    ticks(9);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk_centre("async_rst");
    chk("async_rst_sr",  32'(bus.score_r),   0);
    chk("async_rst_hit", 32'(bus.hit),       0);
    chk("async_rst_pl",  32'(bus.point_l),   0);
    chk("async_rst_pr",  32'(bus.point_r),   0);
    chk("async_rst_go",  32'(bus.game_over), 0);
    @(negedge clk) reset_n = 1'b1;
    do_tick();
    chk_centre("after_rst_serve");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pong_ball.md
Name: pong_ball

Overview:
- Ball-motion and scoring engine for the Pong game.
- Sits directly downstream of the two paddle controllers: consumes their paddle_y outputs and the shared per-frame refresh_tick.
- Moves the ball, resolves wall and paddle collisions, tracks both scores, and sequences serve, play, point and game-over.
- Outputs drive the pixel renderer, the score display and the sound trigger.

Parameters:
- SCREEN_W, 640, active width in pixels
- SCREEN_H, 480, active height in pixels
- BALL_SIZE, 8, ball edge length in pixels (square)
- BALL_SPEED, 2, pixels moved per refresh_tick on each axis
- PADDLE_HEIGHT, 72, paddle height; must match the paddle instances
- L_PADDLE_FACE, 40, x of the left paddle's right (hitting) edge
- R_PADDLE_FACE, 600, x of the right paddle's left (hitting) edge
- POINT_FRAMES, 60, refresh ticks to hold after a point
- WIN_SCORE, 7, score that ends the game

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- refresh_tick  in  1  one-clk pulse per frame; all motion happens only on it
- serve  in  1  level; launches the ball or restarts after game over
- paddle_l_y  in  10  left paddle top y
- paddle_r_y  in  10  right paddle top y
- ball_x  out  10  ball left x
- ball_y  out  10  ball top y
- score_l  out  4  left player score
- score_r  out  4  right player score
- hit  out  1  one-clk pulse on a paddle bounce
- point_l  out  1  one-clk pulse when left scores
- point_r  out  1  one-clk pulse when right scores
- game_over  out  1  high while in GAME_OVER

Behaviour:
- Reset (async, reset_n low):
  - ball_x=316, ball_y=236 (centre), scores 0.
  - State SERVE, dir_x=right, dir_y=down.
  - hit, point_l, point_r, game_over all 0; frame counter 0.
- States: SERVE, PLAY, POINT, GAME_OVER.
- SERVE:
  - Ball held at centre.
  - serve high on any clk → PLAY on the next clk; dir_y toggles on each serve.
- PLAY: on each refresh_tick, evaluate using current values. x and y rules apply in the same tick.
- Y axis:
  - Moving up and ball_y ≤ BALL_SPEED: ball_y=0, dir_y=down.
  - Moving down and ball_y+BALL_SIZE+BALL_SPEED ≥ SCREEN_H: ball_y=SCREEN_H-BALL_SIZE (472), dir_y=up.
  - Otherwise ball_y ± BALL_SPEED.
- Vertical overlap with paddle P: ball_y+BALL_SIZE > P_y AND ball_y < P_y+PADDLE_HEIGHT.
- X axis, moving right:
  - Bounce: ball_x+BALL_SIZE+BALL_SPEED ≥ R_PADDLE_FACE AND ball_x+BALL_SIZE ≤ R_PADDLE_FACE AND overlap with right paddle → ball_x=R_PADDLE_FACE-BALL_SIZE (592), dir_x=left, hit pulse.
  - Else miss: ball_x+BALL_SIZE+BALL_SPEED ≥ SCREEN_W → score_l+1, point_l pulse, enter POINT.
  - Else ball_x+BALL_SPEED.
- X axis, moving left: mirror of the above.
  - Bounce: ball_x ≤ L_PADDLE_FACE+BALL_SPEED AND ball_x ≥ L_PADDLE_FACE AND overlap with left paddle → ball_x=40, dir_x=right, hit pulse.
  - Miss: ball_x ≤ BALL_SPEED → score_r+1, point_r pulse, enter POINT.
- Once the ball is past a paddle face it can no longer bounce on that side.
- POINT:
  - Ball frozen; count POINT_FRAMES ticks.
  - Then GAME_OVER if either score == WIN_SCORE; otherwise SERVE with the ball recentred and dir_x toward the player who lost the point.
- GAME_OVER:
  - game_over=1, ball centred.
  - serve high → clear scores, dir_x=right, enter SERVE.
  - Keep serve edge-qualified: a serve level held from GAME_OVER must deassert before it can launch again.
- Scores saturate at WIN_SCORE and never wrap.
- Pulses last exactly one clk.
- refresh_tick outside PLAY/POINT has no effect.
- Reset mid-play aborts immediately to the reset values.

Test Plan:
- Reset, then serve, then 117 ticks → ball_y=470, ball_x=550; tick 118 → ball_y=472, dir_y=up (bottom bounce).
- Serve with paddle_r_y=400 → at tick 138: ball_x=592, ball_y=432, one-clk hit pulse; tick 139 → ball_x=590.
- Serve with paddle_r_y=0 → no hit; tick 158 (ball_x=630) → point_l pulse, score_l=1; ball frozen 60 ticks, then SERVE with ball at (316,236).
- Force score_l to 6 via repeated misses, then one more miss → score_l=7; after 60 ticks game_over=1; serve held from before does nothing; serve release then re-press → scores 0, state SERVE.
- Assert reset_n low mid-PLAY between ticks → outputs return to reset values asynchronously; no pulses.
- Ball moving up with ball_y=2 → next tick ball_y=0, dir_y=down; ball moving left at ball_x=42 with left overlap → ball_x=40, hit pulse.
